// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, with a
// registered result and final borrow presented alongside a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bw;
  logic [CW-1:0]    cnt;

  logic a_i;
  logic b_i;
  logic d_i;
  logic bw_next;

  // Full-subtractor cell working on the current LSBs of the operand shifters.
  always_comb begin
    a_i     = a_sr[0];
    b_i     = b_sr[0];
    d_i     = a_i ^ b_i ^ bw;
    bw_next = (~a_i & b_i) | (~(a_i ^ b_i) & bw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            bw     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d_i, res_sr[WIDTH-1:1]};
          bw     <= bw_next;
          cnt    <= cnt + CW'(1);
          // diff only ever sees the fully assembled word, never the shifter.
          if (cnt == CW'(WIDTH - 1)) begin
            diff       <= {d_i, res_sr[WIDTH-1:1]};
            borrow_out <= bw_next;
            done       <= 1'b1;
            cnt        <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor: latency, result, borrow,
// back-to-back issue, operand latching, idle hold and asynchronous reset abort.
module tb_serial_subtractor;
  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_res;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; drives the request and confirms acceptance.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH:0] exp);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("done_after_accept", {31'd0, done}, 32'd0);
  endtask

  // Waits (bounded) for done, checks latency, result, hold and pulse width.
  task automatic wait_done(input string tag, input bit keep_start, output int t_done);
    int lat;
    bit got;
    logic [WIDTH:0] exp;
    lat = 1;
    got = 0;
    t_done = 0;
    while (lat < WIDTH + 6) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        got = 1;
        break;
      end
      check({tag, "_no_partial"}, {15'd0, borrow_out, diff}, {15'd0, last_res});
    end
    check({tag, "_latency"}, lat, WIDTH + 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (got) begin
      t_done = cyc;
      check({tag, "_result"}, {15'd0, borrow_out, diff}, {15'd0, exp});
      last_res = exp;
      if (!keep_start) begin
        @(negedge clk);
        start = 1'b0;
      end
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
      check({tag, "_hold"}, {15'd0, borrow_out, diff}, {15'd0, last_res});
    end
  endtask

  task automatic do_op(input string tag, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [WIDTH:0] exp);
    int t;
    @(negedge clk);
    issue(av, bv, exp);
    @(negedge clk);
    start = 1'b0;
    wait_done(tag, 1'b0, t);
  endtask

  initial begin
    int t1;
    int t2;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rd;

    rst_n = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    last_res = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {15'd0, borrow_out, diff}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op("sub_5_3",       16'h0005, 16'h0003, {1'b0, 16'h0002});
    do_op("sub_3_5",       16'h0003, 16'h0005, {1'b1, 16'hFFFE});
    do_op("sub_0_1",       16'h0000, 16'h0001, {1'b1, 16'hFFFF});
    do_op("sub_8000_8000", 16'h8000, 16'h8000, {1'b0, 16'h0000});
    do_op("sub_ffff_0",    16'hFFFF, 16'h0000, {1'b0, 16'hFFFF});
    do_op("sub_0_ffff",    16'h0000, 16'hFFFF, {1'b1, 16'h0001});

    // Idle with start low: outputs hold while the operand inputs wander
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'hA5A5 ^ 16'(i);
      b = 16'h5A5A;
      @(posedge clk); #1;
      check("idle_hold", {15'd0, borrow_out, diff}, {15'd0, last_res});
      check("idle_done", {30'd0, busy, done}, 32'd0);
    end

    // Start held high, operands changed after acceptance, back-to-back issue
    @(negedge clk);
    issue(16'h1111, 16'h0022, {1'b0, 16'h10EF});
    @(negedge clk);
    a = 16'h0001;
    b = 16'h0100;
    exp_q.push_back({1'b1, 16'hFF01});
    wait_done("b2b_first", 1'b1, t1);
    @(posedge clk); #1;
    check("b2b_reaccept", {31'd0, busy}, 32'd1);
    wait_done("b2b_second", 1'b0, t2);
    check("b2b_interval", t2 - t1, WIDTH + 2);

    // Reset eight edges into an operation
    @(negedge clk);
    issue(16'h0F0F, 16'h0101, '0);
    void'(exp_q.pop_back());
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {15'd0, borrow_out, diff}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_held", {30'd0, busy, done}, 32'd0);
    end
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h1234, 16'h0234, {1'b0, 16'h1000});
    @(negedge clk);
    start = 1'b0;
    wait_done("after_reset", 1'b0, t1);

    // Random operands against a comparison/difference model
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = (i % 10 == 0) ? ra : 16'($urandom_range(0, 65535));
      rd = ra - rb;
      do_op("random", ra, rb, {(ra < rb), rd});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
